// File: rtl/pipe_cla_addsub_pkg.sv
// Shared definitions for the pipelined CLA adder/subtractor.
// Contents:
//   SEG_W            width of one carry-look-ahead segment
//   OP_ADD..OP_SBB   operation encodings presented on in_op
//   sum_off/skw_w/skw_off
//                    offsets into the flattened per-stage registers.
//                    Every stage keeps a different number of bits, so the
//                    stages are packed back to back in one vector.
package pipe_cla_addsub_pkg;

  localparam int SEG_W = 16;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  // Stage k holds sum segments 0..k, i.e. (k+1)*SEG_W bits.
  function automatic int sum_off(int k);
    return SEG_W * k * (k + 1) / 2;
  endfunction

  // Stage k skew: A and b' segments k+1..seg-1 plus the two operand MSBs.
  function automatic int skw_w(int k, int seg);
    return 2 + 2 * (seg - 1 - k) * SEG_W;
  endfunction

  function automatic int skw_off(int k, int seg);
    int o;
    o = 0;
    for (int j = 0; j < k; j++) o += skw_w(j, seg);
    return o;
  endfunction

endpackage

// File: rtl/cla_16bits.sv
// 16-bit carry-look-ahead adder: four 4-bit groups with group
// generate/propagate feeding a second look-ahead level.
// Ports:
//   i_a, i_b  16-bit addends
//   i_cin     carry into bit 0
//   o_sum     16-bit sum
//   o_cout    carry out of bit 15
module cla_16bits (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);
  logic [15:0] w_g;
  logic [15:0] w_p;
  logic [15:0] w_c;
  logic [3:0]  w_gg;
  logic [3:0]  w_gp;
  logic [4:0]  w_gc;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  for (genvar j = 0; j < 4; j++) begin : g_grp
    localparam int B = 4 * j;
    assign w_gg[j] = w_g[B+3] | (w_p[B+3] & w_g[B+2]) | (w_p[B+3] & w_p[B+2] & w_g[B+1])
                   | (w_p[B+3] & w_p[B+2] & w_p[B+1] & w_g[B]);
    assign w_gp[j] = &w_p[B +: 4];

    // Bit carries inside the group, driven by the group carry-in.
    assign w_c[B]   = w_gc[j];
    assign w_c[B+1] = w_g[B] | (w_p[B] & w_gc[j]);
    assign w_c[B+2] = w_g[B+1] | (w_p[B+1] & w_g[B]) | (w_p[B+1] & w_p[B] & w_gc[j]);
    assign w_c[B+3] = w_g[B+2] | (w_p[B+2] & w_g[B+1]) | (w_p[B+2] & w_p[B+1] & w_g[B])
                    | (w_p[B+2] & w_p[B+1] & w_p[B] & w_gc[j]);
  end

  // Second-level look-ahead across the four groups.
  assign w_gc[0] = i_cin;
  assign w_gc[1] = w_gg[0] | (w_gp[0] & i_cin);
  assign w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
  assign w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);
  assign w_gc[4] = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                 | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & i_cin);

  assign o_sum  = w_p ^ w_c;
  assign o_cout = w_gc[4];
endmodule

// File: rtl/pipe_cla_addsub.sv
// Pipelined add/subtract: one 16-bit CLA segment resolved per stage, carry
// registered between stages, valid/ready handshake with a single global
// stall enable. Latency WIDTH/16 cycles, one operation per cycle.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        input handshake (in_ready = !out_valid | out_ready)
//   in_op, in_a, in_b, in_cin  operation, operands, carry/borrow in
//   out_valid/out_ready      output handshake
//   out_sum, out_cout, out_ovf, out_zero  result and flags
module pipe_cla_addsub
  import pipe_cla_addsub_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);
  localparam int SEG    = WIDTH / SEG_W;
  localparam int SUM_T  = sum_off(SEG);
  localparam int SKW_T  = skw_off(SEG, SEG);
  localparam int SUM_LO = sum_off(SEG - 1);
  localparam int MSB_LO = skw_off(SEG - 1, SEG);

  logic             w_en;
  logic [WIDTH-1:0] w_bx;
  logic             w_c0;
  logic [SEG-1:0]   w_vld_nx;
  logic [SEG-1:0]   w_co_nx;
  logic [SUM_T-1:0] w_sum_nx;
  logic [SKW_T-1:0] w_skw_nx;
  logic             w_zero_nx;
  logic [1:0]       w_msb_out;

  logic [SEG-1:0]   r_vld;
  logic [SEG-1:0]   r_co;
  logic [SUM_T-1:0] r_sum;
  logic [SKW_T-1:0] r_skw;
  logic             r_zero;

  assign w_en     = !r_vld[SEG-1] || out_ready;
  assign in_ready = w_en;

  assign w_bx = (in_op == OP_SUB || in_op == OP_SBB) ? ~in_b : in_b;

  always_comb begin
    w_c0 = 1'b0;
    case (in_op)
      OP_ADC:  w_c0 = in_cin;
      OP_SUB:  w_c0 = 1'b1;
      OP_SBB:  w_c0 = ~in_cin;
      default: w_c0 = 1'b0;
    endcase
  end

  for (genvar k = 0; k < SEG; k++) begin : g_stg
    localparam int HI_W = (SEG - k) * SEG_W;  // operand segments k..SEG-1
    localparam int SU_W = (k + 1) * SEG_W;
    localparam int SU_O = sum_off(k);
    localparam int SK_W = skw_w(k, SEG);
    localparam int SK_O = skw_off(k, SEG);

    logic [HI_W-1:0]  w_ain;
    logic [HI_W-1:0]  w_bin;
    logic [1:0]       w_msb;  // {A msb, b' msb}
    logic             w_ci;
    logic [SEG_W-1:0] w_s;
    logic             w_co;

    if (k == 0) begin : g_in
      localparam int PO = 0;
      assign w_ain    = in_a;
      assign w_bin    = w_bx;
      assign w_msb    = {in_a[WIDTH-1], w_bx[WIDTH-1]};
      assign w_ci     = w_c0;
      assign w_vld_nx[k] = in_valid;
      assign w_sum_nx[SU_O +: SU_W] = w_s;
    end else begin : g_in
      // Previous stage skew layout, LSB first: msbs, b' segments, A segments.
      localparam int PO = skw_off(k - 1, SEG);
      assign w_msb    = r_skw[PO +: 2];
      assign w_bin    = r_skw[PO + 2 +: HI_W];
      assign w_ain    = r_skw[PO + 2 + HI_W +: HI_W];
      assign w_ci     = r_co[k-1];
      assign w_vld_nx[k] = r_vld[k-1];
      assign w_sum_nx[SU_O +: SU_W] = {w_s, r_sum[sum_off(k - 1) +: k * SEG_W]};
    end

    cla_16bits u_cla (
      .i_a    (w_ain[SEG_W-1:0]),
      .i_b    (w_bin[SEG_W-1:0]),
      .i_cin  (w_ci),
      .o_sum  (w_s),
      .o_cout (w_co)
    );

    assign w_co_nx[k] = w_co;

    if (k < SEG - 1) begin : g_sk
      assign w_skw_nx[SK_O +: SK_W] = {w_ain[HI_W-1:SEG_W], w_bin[HI_W-1:SEG_W], w_msb};
    end else begin : g_sk
      // Last stage only keeps the MSBs for the overflow flag.
      assign w_skw_nx[SK_O +: SK_W] = w_msb;
    end
  end

  assign w_zero_nx = ~|w_sum_nx[SUM_LO +: WIDTH];

  // Data registers advance with bubbles too; only the stall freezes them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld  <= '0;
      r_co   <= '0;
      r_sum  <= '0;
      r_skw  <= '0;
      r_zero <= 1'b0;
    end else if (w_en) begin
      r_vld  <= w_vld_nx;
      r_co   <= w_co_nx;
      r_sum  <= w_sum_nx;
      r_skw  <= w_skw_nx;
      r_zero <= w_zero_nx;
    end
  end

  assign w_msb_out = r_skw[MSB_LO +: 2];

  assign out_valid = r_vld[SEG-1];
  assign out_sum   = r_sum[SUM_LO +: WIDTH];
  assign out_cout  = r_co[SEG-1];
  assign out_ovf   = (w_msb_out[1] == w_msb_out[0]) && (out_sum[WIDTH-1] != w_msb_out[1]);
  assign out_zero  = r_zero;
endmodule

// File: tb/tb_pipe_cla_addsub.sv
module tb_pipe_cla_addsub;
  import pipe_cla_addsub_pkg::*;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
    int          acc;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;
  bit   lat_on = 0;
  bit   fire32;
  logic ir32_s, ov32_s;
  ent_t sb [3][$];

  logic        iv16, ir16, ov16, or16, cin16, co16, ovf16, z16;
  logic [1:0]  op16;
  logic [15:0] a16, b16, s16;
  logic        iv32, ir32, ov32, or32, cin32, co32, ovf32, z32;
  logic [1:0]  op32;
  logic [31:0] a32, b32, s32;
  logic        iv64, ir64, ov64, or64, cin64, co64, ovf64, z64;
  logic [1:0]  op64;
  logic [63:0] a64, b64, s64;

  pipe_cla_addsub #(.WIDTH(16)) u_d16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .in_op(op16), .in_a(a16), .in_b(b16),
    .in_cin(cin16), .out_valid(ov16), .out_ready(or16), .out_sum(s16), .out_cout(co16),
    .out_ovf(ovf16), .out_zero(z16));
  pipe_cla_addsub #(.WIDTH(32)) u_d32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_op(op32), .in_a(a32), .in_b(b32),
    .in_cin(cin32), .out_valid(ov32), .out_ready(or32), .out_sum(s32), .out_cout(co32),
    .out_ovf(ovf32), .out_zero(z32));
  pipe_cla_addsub #(.WIDTH(64)) u_d64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .in_op(op64), .in_a(a64), .in_b(b64),
    .in_cin(cin64), .out_valid(ov64), .out_ready(or64), .out_sum(s64), .out_cout(co64),
    .out_ovf(ovf64), .out_zero(z64));

  // Reference: unsigned and signed integer arithmetic on wide values.
  function automatic ent_t model(int w, logic [1:0] op, logic [63:0] a, logic [63:0] b, logic cin);
    ent_t e;
    logic signed [67:0] md, half, ua, ub, sa, sb2, c, ur, sr, m1;
    md   = 68'sd1 <<< w;
    half = md >>> 1;
    m1   = md - 68'sd1;
    ua   = $signed({4'b0, a});
    ub   = $signed({4'b0, b});
    sa   = a[w-1] ? ua - md : ua;
    sb2  = b[w-1] ? ub - md : ub;
    c    = 68'sd0;
    if ((op == OP_ADC || op == OP_SBB) && cin) c = 68'sd1;
    if (op == OP_SUB || op == OP_SBB) begin
      ur = ua - ub - c;
      sr = sa - sb2 - c;
      e.cout = (ur >= 68'sd0);
    end else begin
      ur = ua + ub + c;
      sr = sa + sb2 + c;
      e.cout = (ur >= md);
    end
    e.sum  = ur[63:0] & m1[63:0];
    e.ovf  = (sr < -half) || (sr >= half);
    e.zero = (e.sum == 64'd0);
    e.acc  = 0;
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic score(int i, int w, int seg, logic iv, logic ir, logic [1:0] op,
                       logic [63:0] a, logic [63:0] b, logic cin, logic ov, logic ordy,
                       logic [63:0] s, logic co, logic of, logic z);
    ent_t  e;
    string t;
    t = $sformatf("w%0d", w);
    chk({t, " in_ready"}, 64'(ir), 64'(!ov || ordy));
    if (sb[i].size() == 0) begin
      chk({t, " spurious out_valid"}, 64'(ov), 64'(0));
    end else if (ov) begin
      e = sb[i][0];
      chk({t, " sum"}, s, e.sum);
      chk({t, " cout"}, 64'(co), 64'(e.cout));
      chk({t, " ovf"}, 64'(of), 64'(e.ovf));
      chk({t, " zero"}, 64'(z), 64'(e.zero));
      if (lat_on && ordy) chk({t, " latency"}, 64'(cyc - e.acc), 64'(seg));
      if (ordy) void'(sb[i].pop_front());
    end
    if (iv && ir) begin
      e = model(w, op, a, b, cin);
      e.acc = cyc;
      sb[i].push_back(e);
    end
  endtask

  // Called at posedge+1 with inputs set; samples at posedge+2, returns at next posedge+1.
  task automatic cycle();
    #1;
    ir32_s = ir32;
    ov32_s = ov32;
    fire32 = iv32 && ir32 && !rst;
    if (!rst) begin
      score(1, 16, 1, iv16, ir16, op16, 64'(a16), 64'(b16), cin16, ov16, or16, 64'(s16), co16, ovf16, z16);
      score(0, 32, 2, iv32, ir32, op32, 64'(a32), 64'(b32), cin32, ov32, or32, 64'(s32), co32, ovf32, z32);
      score(2, 64, 4, iv64, ir64, op64, a64, b64, cin64, ov64, or64, s64, co64, ovf64, z64);
    end
    @(posedge clk);
    cyc++;
    if (rst) begin
      sb[0].delete();
      sb[1].delete();
      sb[2].delete();
    end
    #1;
  endtask

  task automatic chk_rst();
    chk("w32 rst out_valid", 64'(ov32), 64'(0));
    chk("w32 rst out_sum", 64'(s32), 64'(0));
    chk("w32 rst out_cout", 64'(co32), 64'(0));
    chk("w32 rst out_ovf", 64'(ovf32), 64'(0));
    chk("w32 rst out_zero", 64'(z32), 64'(0));
    chk("w16 rst out_valid", 64'(ov16), 64'(0));
    chk("w64 rst out_valid", 64'(ov64), 64'(0));
    chk("w64 rst out_sum", s64, 64'(0));
  endtask

  task automatic put32(logic [1:0] op, logic [31:0] a, logic [31:0] b, logic cin);
    iv32 = 1'b1; op32 = op; a32 = a; b32 = b; cin32 = cin;
    cycle();
    iv32 = 1'b0;
  endtask

  task automatic rnd_ops(output logic [1:0] op, output logic [63:0] a, output logic [63:0] b,
                         output logic cin);
    op  = 2'($urandom);
    cin = 1'($urandom);
    a   = {$urandom, $urandom};
    b   = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      1: b = ~a;
      2: b = a;
      default: ;
    endcase
  endtask

  task automatic rnd_all();
    logic [1:0]  op;
    logic [63:0] a, b;
    logic        cin;
    rnd_ops(op, a, b, cin); op16 = op; a16 = a[15:0]; b16 = b[15:0]; cin16 = cin;
    rnd_ops(op, a, b, cin); op32 = op; a32 = a[31:0]; b32 = b[31:0]; cin32 = cin;
    rnd_ops(op, a, b, cin); op64 = op; a64 = a;       b64 = b;       cin64 = cin;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  top;
    logic [63:0] ta, tb2;
    logic        tc;
    int          k;

    rst = 1'b1;
    iv16 = 0; or16 = 1; op16 = 0; a16 = 0; b16 = 0; cin16 = 0;
    iv32 = 0; or32 = 1; op32 = 0; a32 = 0; b32 = 0; cin32 = 0;
    iv64 = 0; or64 = 1; op64 = 0; a64 = 0; b64 = 0; cin64 = 0;
    @(posedge clk); #1;
    cycle();
    cycle();
    rst = 1'b0;
    chk_rst();

    // Directed 32-bit operations, unstalled: latency must be 2.
    lat_on = 1;
    put32(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    put32(OP_ADD, 32'h0000_FFFF, 32'h0000_0001, 1'b0);
    put32(OP_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0);
    put32(OP_ADC, 32'd7, 32'd8, 1'b1);
    put32(OP_SBB, 32'd5, 32'd3, 1'b1);
    put32(OP_SUB, 32'd3, 32'd5, 1'b0);
    put32(OP_ADD, 32'd1, 32'd1, 1'b1);
    put32(OP_SUB, 32'd5, 32'd5, 1'b0);
    put32(OP_SBB, 32'h0000_0000, 32'h0000_0000, 1'b0);
    put32(OP_ADC, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
    repeat (4) cycle();
    chk("w32 directed drained", 64'(sb[0].size()), 64'(0));
    lat_on = 0;

    // Stream of 8 with a 3-cycle output stall mid-stream.
    k = 0;
    for (int n = 0; n < 8; n++) begin
      rnd_ops(top, ta, tb2, tc);
      iv32 = 1'b1; op32 = top; a32 = ta[31:0]; b32 = tb2[31:0]; cin32 = tc;
      do begin
        or32 = !(k >= 4 && k < 7);
        cycle();
        if (k >= 4 && k < 7) begin
          chk("w32 stall in_ready", 64'(ir32_s), 64'(0));
          chk("w32 stall out_valid", 64'(ov32_s), 64'(1));
        end
        k++;
      end while (!fire32 && k < 60);
      chk("w32 stream accept", 64'(fire32), 64'(1));
    end
    iv32 = 1'b0; or32 = 1'b1;
    repeat (6) cycle();
    chk("w32 stream drained", 64'(sb[0].size()), 64'(0));

    // Reset with two operations in flight.
    put32(OP_ADD, 32'h1234_5678, 32'h1111_1111, 1'b0);
    put32(OP_SUB, 32'h0000_0010, 32'h0000_0001, 1'b0);
    rst = 1'b1; or32 = 1'b0; iv32 = 1'b1;
    cycle();
    rst = 1'b0; or32 = 1'b1; iv32 = 1'b0;
    chk_rst();
    cycle();
    chk("w32 in_ready after rst", 64'(ir32_s), 64'(1));
    repeat (5) cycle();

    // Back-to-back random traffic on all widths, full throughput.
    lat_on = 1;
    iv16 = 1; iv32 = 1; iv64 = 1;
    or16 = 1; or32 = 1; or64 = 1;
    repeat (1000) begin
      rnd_all();
      cycle();
    end
    iv16 = 0; iv32 = 0; iv64 = 0;
    repeat (6) cycle();
    lat_on = 0;

    // Random valid and ready on all widths.
    repeat (300) begin
      rnd_all();
      iv16 = ($urandom_range(0, 3) != 0); or16 = ($urandom_range(0, 3) != 0);
      iv32 = ($urandom_range(0, 3) != 0); or32 = ($urandom_range(0, 3) != 0);
      iv64 = ($urandom_range(0, 3) != 0); or64 = ($urandom_range(0, 3) != 0);
      cycle();
    end
    iv16 = 0; iv32 = 0; iv64 = 0;
    or16 = 1; or32 = 1; or64 = 1;
    repeat (12) cycle();
    chk("w16 final drained", 64'(sb[1].size()), 64'(0));
    chk("w32 final drained", 64'(sb[0].size()), 64'(0));
    chk("w64 final drained", 64'(sb[2].size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
